// File: rtl/debounce_bank.sv
// rtl/debounce_bank.sv - N-channel push-button debouncer with press/release/long/repeat pulses
// Channels share one free-running tick prescaler; each has its own synchronizer and lockout FSM.
module debounce_bank #(
    parameter int N          = 4,
    parameter int TICK_DIV   = 100_000,
    parameter int DEB_TICKS  = 1,
    parameter int LONG_TICKS = 1000,
    parameter int REP_TICKS  = 200,
    parameter int REPEAT_EN  = 1
) (
    input  logic         ck,
    input  logic         rst,
    input  logic [N-1:0] button,
    output logic [N-1:0] level,
    output logic [N-1:0] press,
    output logic [N-1:0] rel,
    output logic [N-1:0] long,
    output logic [N-1:0] rep,
    output logic         tick
);

    localparam int CNT_MAX = (LONG_TICKS >= REP_TICKS)
                           ? ((LONG_TICKS >= DEB_TICKS) ? LONG_TICKS : DEB_TICKS)
                           : ((REP_TICKS >= DEB_TICKS) ? REP_TICKS : DEB_TICKS);
    localparam int CW = $clog2(CNT_MAX + 1);
    localparam int PW = $clog2(TICK_DIV);

    localparam logic [CW-1:0] DEB_C    = CW'(DEB_TICKS);
    localparam logic [CW-1:0] LONG_C   = CW'(LONG_TICKS);
    localparam logic [CW-1:0] REP_C    = CW'(REP_TICKS);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PUSH     = 3'd1,
        HELD     = 3'd2,
        RPT      = 3'd3,
        NOT_PUSH = 3'd4
    } state_t;

    logic [PW-1:0] pre;

    always_ff @(posedge ck) begin
        if (rst) begin
            pre <= '0;
        end else if (pre == PRE_LAST) begin
            pre <= '0;
        end else begin
            pre <= pre + 1'b1;
        end
    end

    assign tick = (pre == PRE_LAST);

    for (genvar g = 0; g < N; g++) begin : g_ch
        state_t        state, state_n;
        logic [CW-1:0] cnt, cnt_n, cnt_inc;
        logic [1:0]    sync;
        logic          s;
        logic          press_n, rel_n, long_n, rep_n;
        logic          level_r, press_r, rel_r, long_r, rep_r;

        assign s       = sync[1];
        assign cnt_inc = cnt + 1'b1;

        // A falling synchronized input beats a same-cycle tick in HELD/RPT.
        always_comb begin
            state_n = state;
            cnt_n   = cnt;
            press_n = 1'b0;
            rel_n   = 1'b0;
            long_n  = 1'b0;
            rep_n   = 1'b0;
            case (state)
                IDLE: begin
                    if (s) begin
                        state_n = PUSH;
                        cnt_n   = '0;
                        press_n = 1'b1;
                    end
                end
                PUSH: begin
                    if (tick) begin
                        cnt_n = cnt_inc;
                        if (cnt_inc == DEB_C) begin
                            state_n = HELD;
                        end
                    end
                end
                HELD: begin
                    if (!s) begin
                        state_n = NOT_PUSH;
                        cnt_n   = '0;
                        rel_n   = 1'b1;
                    end else if (tick) begin
                        cnt_n = cnt_inc;
                        if (cnt_inc == LONG_C) begin
                            state_n = RPT;
                            cnt_n   = '0;
                            long_n  = 1'b1;
                        end
                    end
                end
                RPT: begin
                    if (!s) begin
                        state_n = NOT_PUSH;
                        cnt_n   = '0;
                        rel_n   = 1'b1;
                    end else if (tick) begin
                        cnt_n = cnt_inc;
                        if (cnt_inc == REP_C) begin
                            cnt_n = '0;
                            rep_n = (REPEAT_EN != 0);
                        end
                    end
                end
                NOT_PUSH: begin
                    if (tick) begin
                        cnt_n = cnt_inc;
                        if (cnt_inc == DEB_C) begin
                            state_n = IDLE;
                        end
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            endcase
        end

        always_ff @(posedge ck) begin
            if (rst) begin
                state   <= IDLE;
                cnt     <= '0;
                sync    <= '0;
                level_r <= 1'b0;
                press_r <= 1'b0;
                rel_r   <= 1'b0;
                long_r  <= 1'b0;
                rep_r   <= 1'b0;
            end else begin
                state   <= state_n;
                cnt     <= cnt_n;
                sync    <= {sync[0], button[g]};
                level_r <= (state_n == PUSH) || (state_n == HELD) || (state_n == RPT);
                press_r <= press_n;
                rel_r   <= rel_n;
                long_r  <= long_n;
                rep_r   <= rep_n;
            end
        end

        assign level[g] = level_r;
        assign press[g] = press_r;
        assign rel[g]   = rel_r;
        assign long[g]  = long_r;
        assign rep[g]   = rep_r;
    end

endmodule

// File: tb/tb_debounce_bank.sv
// tb/tb_debounce_bank.sv - randomized and directed bench for debounce_bank against a tick-count model
module tb_debounce_bank;

    localparam int N    = 2;
    localparam int TD   = 4;
    localparam int DEB  = 2;
    localparam int LONG = 6;
    localparam int REP  = 3;

    logic         ck = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] button = '0;

    logic [N-1:0] lvl_a, prs_a, rel_a, lng_a, rep_a;
    logic [N-1:0] lvl_b, prs_b, rel_b, lng_b, rep_b;
    logic         tick_a, tick_b;

    always #5 ck = ~ck;

    debounce_bank #(.N(N), .TICK_DIV(TD), .DEB_TICKS(DEB), .LONG_TICKS(LONG),
                    .REP_TICKS(REP), .REPEAT_EN(1)) dut_a (
        .ck(ck), .rst(rst), .button(button), .level(lvl_a), .press(prs_a),
        .rel(rel_a), .long(lng_a), .rep(rep_a), .tick(tick_a));

    debounce_bank #(.N(N), .TICK_DIV(TD), .DEB_TICKS(DEB), .LONG_TICKS(LONG),
                    .REP_TICKS(REP), .REPEAT_EN(0)) dut_b (
        .ck(ck), .rst(rst), .button(button), .level(lvl_b), .press(prs_b),
        .rel(rel_b), .long(lng_b), .rep(rep_b), .tick(tick_b));

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: accepted level plus tick counts since the last accepted press / release.
    bit           m_lvl  [2][N];
    int           m_held [2][N];
    int           m_relt [2][N];
    bit           m_s1 [N];
    bit           m_s2 [N];
    int           m_cyc;
    logic [N-1:0] e_prs [2];
    logic [N-1:0] e_rel [2];
    logic [N-1:0] e_lng [2];
    logic [N-1:0] e_rep [2];
    bit           e_tick;

    int cyc_no = 0;
    int last_evt [N];
    int np_a [N], nr_a [N], nl_a [N], nrep_a [N], nl_b [N], nrep_b [N];

    task automatic clr_counts();
        for (int c = 0; c < N; c++) begin
            np_a[c] = 0; nr_a[c] = 0; nl_a[c] = 0; nrep_a[c] = 0; nl_b[c] = 0; nrep_b[c] = 0;
        end
    endtask

    task automatic model_edge();
        bit t;
        for (int i = 0; i < 2; i++) begin
            e_prs[i] = '0; e_rel[i] = '0; e_lng[i] = '0; e_rep[i] = '0;
        end
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                for (int c = 0; c < N; c++) begin
                    m_lvl[i][c] = 1'b0; m_held[i][c] = 0; m_relt[i][c] = DEB;
                end
            end
            for (int c = 0; c < N; c++) begin
                m_s1[c] = 1'b0; m_s2[c] = 1'b0;
            end
            m_cyc  = 0;
            e_tick = 1'b0;
        end else begin
            t = (m_cyc % TD == TD - 1);
            for (int i = 0; i < 2; i++) begin
                for (int c = 0; c < N; c++) begin
                    if (!m_lvl[i][c]) begin
                        if (m_relt[i][c] < DEB) begin
                            if (t) m_relt[i][c]++;
                        end else if (m_s2[c]) begin
                            m_lvl[i][c] = 1'b1; m_held[i][c] = 0; e_prs[i][c] = 1'b1;
                        end
                    end else begin
                        if (m_held[i][c] < DEB) begin
                            if (t) m_held[i][c]++;
                        end else if (!m_s2[c]) begin
                            m_lvl[i][c] = 1'b0; m_relt[i][c] = 0; e_rel[i][c] = 1'b1;
                        end else if (t) begin
                            m_held[i][c]++;
                            if (m_held[i][c] == LONG)
                                e_lng[i][c] = 1'b1;
                            else if (i == 0 && m_held[i][c] > LONG && (m_held[i][c] - LONG) % REP == 0)
                                e_rep[i][c] = 1'b1;
                        end
                    end
                end
            end
            for (int c = 0; c < N; c++) begin
                m_s2[c] = m_s1[c];
                m_s1[c] = button[c];
            end
            m_cyc++;
            e_tick = (m_cyc % TD == TD - 1);
        end
    endtask

    task automatic cycle();
        logic [N-1:0] el_a, el_b;
        @(posedge ck);
        model_edge();
        @(negedge ck);
        cyc_no++;
        for (int c = 0; c < N; c++) begin
            el_a[c] = m_lvl[0][c];
            el_b[c] = m_lvl[1][c];
        end
        check_eq("a_level", 8'(lvl_a), 8'(el_a));
        check_eq("a_press", 8'(prs_a), 8'(e_prs[0]));
        check_eq("a_release", 8'(rel_a), 8'(e_rel[0]));
        check_eq("a_long", 8'(lng_a), 8'(e_lng[0]));
        check_eq("a_rep", 8'(rep_a), 8'(e_rep[0]));
        check_eq("b_level", 8'(lvl_b), 8'(el_b));
        check_eq("b_press", 8'(prs_b), 8'(e_prs[1]));
        check_eq("b_release", 8'(rel_b), 8'(e_rel[1]));
        check_eq("b_long", 8'(lng_b), 8'(e_lng[1]));
        check_eq("b_rep", 8'(rep_b), 8'(e_rep[1]));
        check_eq("tick", 8'(tick_a), 8'(e_tick));
        check_eq("tick_b", 8'(tick_b), 8'(e_tick));
        for (int c = 0; c < N; c++) begin
            np_a[c]   += int'(prs_a[c]);
            nr_a[c]   += int'(rel_a[c]);
            nl_a[c]   += int'(lng_a[c]);
            nrep_a[c] += int'(rep_a[c]);
            nl_b[c]   += int'(lng_b[c]);
            nrep_b[c] += int'(rep_b[c]);
            if (rep_a[c]) check_eq("rep_gap", 8'(cyc_no - last_evt[c]), 8'(REP * TD));
            if (lng_a[c] || rep_a[c]) last_evt[c] = cyc_no;
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    initial begin
        bit found;
        for (int c = 0; c < N; c++) last_evt[c] = 0;
        clr_counts();

        // 1: reset with buttons held, then press latency
        rst = 1'b1; button = 2'b11;
        run(3);
        check_eq("rst_level", 8'(lvl_a), 8'h0);
        check_eq("rst_tick", 8'(tick_a), 8'h0);
        rst = 1'b0;
        run(2);
        check_eq("press_early", 8'(prs_a), 8'h0);
        run(1);
        check_eq("press_lat", 8'(prs_a), 8'h3);
        check_eq("level_lat", 8'(lvl_a), 8'h3);
        run(1);
        check_eq("press_width", 8'(prs_a), 8'h0);

        // 2: bounce on press
        button = 2'b00;
        run(15);
        clr_counts();
        for (int k = 0; k < 6; k++) begin
            button[0] = (k % 2 == 0);
            run(1);
        end
        button[0] = 1'b1;
        run(20);
        check_eq("bounce_press", 8'(np_a[0]), 8'd1);
        check_eq("bounce_norel", 8'(nr_a[0]), 8'd0);
        check_eq("bounce_level", 8'(lvl_a[0]), 8'd1);
        check_eq("ch1_quiet", 8'(np_a[1]), 8'd0);

        // 3: bounce on release
        clr_counts();
        for (int k = 0; k < 5; k++) begin
            button[0] = (k % 2 == 1);
            run(1);
        end
        button[0] = 1'b0;
        run(12);
        check_eq("bounce_rel", 8'(nr_a[0]), 8'd1);
        check_eq("rel_level", 8'(lvl_a[0]), 8'd0);
        button[0] = 1'b1;
        run(6);

        // 4: long hold on channel 1, repeat on and off
        clr_counts();
        button[1] = 1'b1;
        run(60);
        check_eq("hold_press", 8'(np_a[1]), 8'd1);
        check_eq("hold_long_a", 8'(nl_a[1]), 8'd1);
        check_eq("hold_long_b", 8'(nl_b[1]), 8'd1);
        check_eq("hold_rep_a", 8'(nrep_a[1]), 8'd3);
        check_eq("hold_rep_b", 8'(nrep_b[1]), 8'd0);
        button[1] = 1'b0;
        run(12);

        // 5: release collides with the long tick
        button[0] = 1'b0;
        run(15);
        button[0] = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 60 && !found; k++) begin
            cycle();
            if (m_lvl[0][0] && m_held[0][0] == LONG - 1 && m_cyc % TD == 1) found = 1'b1;
        end
        check_eq("align_found", 8'(found), 8'd1);
        button[0] = 1'b0;
        clr_counts();
        run(12);
        check_eq("collide_nolong", 8'(nl_a[0]), 8'd0);
        check_eq("collide_rel", 8'(nr_a[0]), 8'd1);

        // 6: reset while channel 0 repeats and channel 1 is in release lockout
        button = 2'b00;
        run(15);
        button = 2'b11;
        run(40);
        button[1] = 1'b0;
        run(3);
        rst = 1'b1; button = 2'b11;
        run(1);
        check_eq("rst6_level", 8'(lvl_a), 8'h0);
        check_eq("rst6_rep", 8'(rep_a), 8'h0);
        check_eq("rst6_tick", 8'(tick_a), 8'h0);
        rst = 1'b0;
        run(2);
        check_eq("rst6_early", 8'(prs_a), 8'h0);
        run(1);
        check_eq("rst6_press", 8'(prs_a), 8'h3);

        // random traffic with occasional resets
        for (int k = 0; k < 2000; k++) begin
            for (int c = 0; c < N; c++)
                if ($urandom_range(0, 15) == 0) button[c] = ~button[c];
            rst = ($urandom_range(0, 499) == 0);
            cycle();
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/debounce_bank.md
# debounce_bank

Parametrised N-channel push-button conditioner that replaces the single-button debouncer in the front-panel input path. Each channel has its own synchronizer and lockout state machine, and all channels share one millisecond tick prescaler. Outputs per channel are a clean level plus single-cycle press, release, long-press and auto-repeat pulses for the clock/menu control logic.

## Interface
- N, 4, number of independent button channels (≥1)
- TICK_DIV, 100_000, clock cycles per timing tick (1 ms at 100 MHz; ≥2)
- DEB_TICKS, 1, lockout length after a press or release, in ticks (≥1)
- LONG_TICKS, 1000, ticks from press to long-press pulse (> DEB_TICKS)
- REP_TICKS, 200, ticks between auto-repeat pulses (≥1)
- REPEAT_EN, 1, 1 = emit repeat pulses after long press; 0 = none
- ck  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- button  input  N  raw asynchronous button inputs, active-high
- level  output  N  debounced button level
- press  output  N  1-cycle pulse on accepted press
- release  output  N  1-cycle pulse on accepted release
- long  output  N  1-cycle pulse when hold reaches LONG_TICKS
- rep  output  N  1-cycle auto-repeat pulse
- tick  output  1  shared prescaler tick, 1 cycle every TICK_DIV cycles

## Operation
- Prescaler: counter 0..TICK_DIV-1, wraps to 0. tick = (counter == TICK_DIV-1), decoded from the register. Free-running and shared by all channels.
- Per channel: 2-FF synchronizer `s`, a state register, and a tick counter `cnt` of width $clog2(max(LONG_TICKS, REP_TICKS, DEB_TICKS)+1).
- States and transitions, per channel:
  - IDLE: level=0. If s=1, go to PUSH, cnt←0, pulse press.
  - PUSH (lockout): level=1; s is ignored. cnt increments on tick. When a tick makes cnt==DEB_TICKS, go to HELD; cnt keeps its value.
  - HELD: level=1. If s=0, go to NOT_PUSH, cnt←0, pulse release. Otherwise cnt increments on tick. When a tick makes cnt==LONG_TICKS, go to RPT, cnt←0, pulse long.
  - RPT: level=1. If s=0, go to NOT_PUSH, cnt←0, pulse release. Otherwise cnt increments on tick. When a tick makes cnt==REP_TICKS, cnt←0 and pulse rep, but only if REPEAT_EN=1.
  - NOT_PUSH (lockout): level=0; s is ignored. cnt increments on tick. When a tick makes cnt==DEB_TICKS, go to IDLE.
  - Undefined state codes go to IDLE.
- Simultaneous events: in HELD or RPT, s=0 has priority over a tick in the same cycle. The result is a release pulse with no long and no rep pulse.
- The long timer runs from press entry, so the lockout ticks count toward LONG_TICKS.
- Channels are fully independent; the only shared element is tick.
- All outputs are registered. Exactly one of press, release, long or rep can pulse per channel per cycle.

## Timing
- Reset, asserted for one or more edges:
  - prescaler, cnt and synchronizers go to 0; all states go to IDLE.
  - level, press, release, long, rep and tick are all 0 after the reset edge.
  - Reset mid-operation aborts any pending pulse.
- Button held high across reset release counts as a new press after the normal latency.
- Press latency: if button is first sampled high at edge k, level and press are high after edge k+2. press lasts exactly 1 cycle.
- Release latency after leaving lockout: also 2 edges.
- First tick is high in cycle TICK_DIV-1 after reset release, then every TICK_DIV cycles.
- Lockout duration: DEB_TICKS tick pulses after entry, i.e. between (DEB_TICKS-1)·TICK_DIV+1 and DEB_TICKS·TICK_DIV cycles, depending on tick phase.
- long is the LONG_TICKS-th tick after press entry. rep pulses follow every REP_TICKS ticks exactly.
- Minimum press-to-press spacing: both lockouts plus 4 cycles of synchronizer latency.

## Test plan
Bench parameters: N=2, TICK_DIV=4, DEB_TICKS=2, LONG_TICKS=6, REP_TICKS=3.
1. Hold rst=1 for 3 cycles with button=2'b11 -> all outputs 0 during reset. After release, level=2'b11 and press=2'b11 for exactly one cycle, 2 edges after the first sampling edge.
2. Toggle button[0] every cycle for 6 cycles, then hold it high -> exactly one press[0], level[0] stays 1, no release[0]. Channel 1 outputs unaffected.
3. From HELD, drop button[0] and bounce it for 5 cycles -> one release[0], level[0]=0. The next press is accepted only after the 2nd tick following release.
4. Hold button[1] high for 60 cycles, REPEAT_EN=1 -> press[1], then long[1] on the 6th tick after press entry, then rep[1] every 12 cycles until release. Repeat with REPEAT_EN=0 -> one long[1] and zero rep[1].
5. Release button[0] so s=0 arrives in the same cycle as the tick that would make cnt==LONG_TICKS -> release[0] only, no long[0].
6. Assert rst for 1 cycle while channel 0 is in RPT and channel 1 is in NOT_PUSH -> all outputs 0 next cycle, tick phase restarts. With buttons held high, a fresh press follows 2 edges after reset release.
